lsu_agu_sched: RTL and testbench
================================

Name: lsu_agu_sched

Overview:
Single-AGU scheduler for the LSU. Arbitrates load-issue and store-issue requests onto one shared address adder, computes base+offset, flags misalignment, and holds the result in one output register with a valid/ready handshake to the DTLB/LSQ stage. Sits between the LSU issue logic and address translation.

Parameters:
XLEN, 64, operand width of base/offset
VIRTUAL_ADDR_LEN, 39, generated virtual address width
ROB_INDEX_WIDTH, 6, width of the ROB tag carried with each request

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush_i  input  1  pipeline flush; kills in-flight and same-cycle requests
ld_valid_i  input  1  load request valid
ld_ready_o  output  1  load request accepted this cycle
ld_base_i  input  XLEN  load base operand
ld_offset_i  input  XLEN  load offset (sign-extended immediate)
ld_size_i  input  2  access size: 0=B,1=H,2=W,3=D
ld_rob_idx_i  input  ROB_INDEX_WIDTH  load ROB tag
st_valid_i  input  1  store request valid
st_ready_o  output  1  store request accepted this cycle
st_base_i  input  XLEN  store base operand
st_offset_i  input  XLEN  store offset
st_size_i  input  2  store access size
st_rob_idx_i  input  ROB_INDEX_WIDTH  store ROB tag
out_valid_o  output  1  result register holds valid entry
out_ready_i  input  1  downstream accepts entry
out_addr_o  output  VIRTUAL_ADDR_LEN  generated virtual address
out_is_store_o  output  1  1=store, 0=load
out_size_o  output  2  access size of entry
out_rob_idx_o  output  ROB_INDEX_WIDTH  ROB tag of entry
out_misalign_o  output  1  address not naturally aligned for size

Behaviour:
- Address = base[VA-1:0] + offset[VA-1:0], truncated to VIRTUAL_ADDR_LEN, wrap-around silent (no overflow flag).
- Misalign: size 1 -> addr[0]!=0; size 2 -> addr[1:0]!=0; size 3 -> addr[2:0]!=0; size 0 never.
- can_accept = !out_valid_o | out_ready_i. Grant only when can_accept & !flush_i & !rst.
- Arbitration: one grant per cycle. Only one valid -> grant it. Both valid -> round-robin via 1-bit last_grant (0=load,1=store); grant the one not last granted. last_grant updates only on a grant. Reset value 1 (load wins first conflict).
- ld_ready_o/st_ready_o are the grant bits; combinational from valids, can_accept, flush_i, last_grant. Never both high. Requester holds operands stable until ready.
- Latency: 1 cycle. Granted at edge N -> out_valid_o=1 with result after edge N.
- Output register: loads on grant; on out_ready_i with no grant, out_valid_o clears. Accept + new grant same cycle -> back-to-back, out_valid_o stays 1, fields replaced.
- Full: out_valid_o=1 & !out_ready_i -> both ready low, entry held stable.
- flush_i: next edge out_valid_o=0, no grant that cycle; last_grant unchanged.
- rst (sync): out_valid_o=0, last_grant=1; all data outputs 0; ready outputs 0 while rst high. Reset mid-transfer drops the entry.
- Data outputs hold last value when out_valid_o=0 (no X requirement on checker).

Decomposition:
- Shared package/params.vh: XLEN, VIRTUAL_ADDR_LEN, ROB_INDEX_WIDTH, size encodings (LSU_SIZE_B/H/W/D).
- One sub-module: lsu_agu_rr_arb (2-way round-robin arbiter with last_grant state, enable input). Adder and misalign check stay inline.

Test Plan:
- Single load: base=0x1000, offset=0x8, size=3, rob=5 -> ld_ready_o=1; next cycle out_valid_o=1, addr=0x1008, is_store=0, misalign=0, rob=5.
- Conflict after reset: both valid 3 cycles, out_ready_i=1 -> grants load, store, load; last_grant alternates; out_is_store 0,1,0.
- Backpressure: out_ready_i=0 with entry held -> both ready=0, outputs stable 4 cycles; raise out_ready_i -> pending request granted same cycle, new entry next.
- Misalign/wrap: base=0x7F_FFFF_FFFF, offset=0x2, size=2 -> addr=0x1, misalign=1; size=0 -> misalign=0.
- Flush: out_valid_o=1 and ld_valid_i=1 with flush_i=1 -> ld_ready_o=0; next cycle out_valid_o=0, last_grant unchanged.
- Reset mid-op: assert rst with out_valid_o=1 -> next edge out_valid_o=0, addr=0; first conflict after release grants load.

Source files
------------

// File: rtl/lsu_agu_sched_pkg.sv
// Shared widths, access-size encodings and grant identifiers for the LSU AGU scheduler.
package lsu_agu_sched_pkg;

  localparam int LSU_XLEN    = 64;
  localparam int LSU_VA_LEN  = 39;
  localparam int LSU_ROB_W   = 6;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2,
    LSU_SIZE_D = 2'd3
  } lsu_size_e;

  localparam logic LSU_GNT_LD = 1'b0;
  localparam logic LSU_GNT_ST = 1'b1;

endpackage

// File: rtl/lsu_agu_rr_arb.sv
// Two-way load/store round-robin arbiter; the side not granted last wins a conflict.
module lsu_agu_rr_arb
  import lsu_agu_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_ld,
  input  logic i_req_st,
  output logic o_gnt_ld,
  output logic o_gnt_st
);

  logic r_last_grant;

  always_comb begin
    o_gnt_ld = 1'b0;
    o_gnt_st = 1'b0;
    if (i_en) begin
      if (i_req_ld && (!i_req_st || (r_last_grant == LSU_GNT_ST))) begin
        o_gnt_ld = 1'b1;
      end else if (i_req_st) begin
        o_gnt_st = 1'b1;
      end
    end
  end

  // Reset to "store last" so the first conflict after reset goes to the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= LSU_GNT_ST;
    end else if (o_gnt_ld || o_gnt_st) begin
      r_last_grant <= o_gnt_st;
    end
  end

endmodule

// File: rtl/lsu_agu_sched.sv
// Single shared AGU: arbitrates load/store issue, computes base+offset, flags misalignment,
// and holds one result entry behind a valid/ready handshake toward DTLB/LSQ.
module lsu_agu_sched
  import lsu_agu_sched_pkg::*;
#(
  parameter int XLEN             = LSU_XLEN,
  parameter int VIRTUAL_ADDR_LEN = LSU_VA_LEN,
  parameter int ROB_INDEX_WIDTH  = LSU_ROB_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        ld_valid_i,
  output logic                        ld_ready_o,
  input  logic [XLEN-1:0]             ld_base_i,
  input  logic [XLEN-1:0]             ld_offset_i,
  input  logic [1:0]                  ld_size_i,
  input  logic [ROB_INDEX_WIDTH-1:0]  ld_rob_idx_i,
  input  logic                        st_valid_i,
  output logic                        st_ready_o,
  input  logic [XLEN-1:0]             st_base_i,
  input  logic [XLEN-1:0]             st_offset_i,
  input  logic [1:0]                  st_size_i,
  input  logic [ROB_INDEX_WIDTH-1:0]  st_rob_idx_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [VIRTUAL_ADDR_LEN-1:0] out_addr_o,
  output logic                        out_is_store_o,
  output logic [1:0]                  out_size_o,
  output logic [ROB_INDEX_WIDTH-1:0]  out_rob_idx_o,
  output logic                        out_misalign_o
);

  localparam int VA = VIRTUAL_ADDR_LEN;

  function automatic logic f_misalign(input logic [VA-1:0] addr, input logic [1:0] size);
    logic m;
    case (size)
      LSU_SIZE_H: m = addr[0];
      LSU_SIZE_W: m = |addr[1:0];
      LSU_SIZE_D: m = |addr[2:0];
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

  logic                       r_out_valid;
  logic [VA-1:0]              r_out_addr;
  logic                       r_out_is_store;
  logic [1:0]                 r_out_size;
  logic [ROB_INDEX_WIDTH-1:0] r_out_rob_idx;
  logic                       r_out_misalign;

  logic                       w_can_accept;
  logic                       w_arb_en;
  logic                       w_gnt_ld;
  logic                       w_gnt_st;
  logic [VA-1:0]              w_base;
  logic [VA-1:0]              w_offset;
  logic [VA-1:0]              w_addr;
  logic [1:0]                 w_size;
  logic [ROB_INDEX_WIDTH-1:0] w_rob_idx;
  logic                       w_unused_upper;

  assign w_can_accept = !r_out_valid || out_ready_i;
  assign w_arb_en     = w_can_accept && !flush_i && !rst;

  lsu_agu_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_arb_en),
    .i_req_ld (ld_valid_i),
    .i_req_st (st_valid_i),
    .o_gnt_ld (w_gnt_ld),
    .o_gnt_st (w_gnt_st)
  );

  assign ld_ready_o = w_gnt_ld;
  assign st_ready_o = w_gnt_st;

  // Only the low VA bits reach the adder; the wrap past VA bits is intentionally silent.
  assign w_base    = w_gnt_st ? st_base_i[VA-1:0]   : ld_base_i[VA-1:0];
  assign w_offset  = w_gnt_st ? st_offset_i[VA-1:0] : ld_offset_i[VA-1:0];
  assign w_size    = w_gnt_st ? st_size_i           : ld_size_i;
  assign w_rob_idx = w_gnt_st ? st_rob_idx_i        : ld_rob_idx_i;
  assign w_addr    = w_base + w_offset;

  assign w_unused_upper = ^{ld_base_i[XLEN-1:VA], ld_offset_i[XLEN-1:VA],
                            st_base_i[XLEN-1:VA], st_offset_i[XLEN-1:VA]};

  // Result register: flush drops the entry but keeps fields; a grant overwrites in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_addr     <= '0;
      r_out_is_store <= 1'b0;
      r_out_size     <= '0;
      r_out_rob_idx  <= '0;
      r_out_misalign <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_gnt_ld || w_gnt_st) begin
      r_out_valid    <= 1'b1;
      r_out_addr     <= w_addr;
      r_out_is_store <= w_gnt_st;
      r_out_size     <= w_size;
      r_out_rob_idx  <= w_rob_idx;
      r_out_misalign <= f_misalign(w_addr, w_size);
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o    = r_out_valid;
  assign out_addr_o     = r_out_addr;
  assign out_is_store_o = r_out_is_store;
  assign out_size_o     = r_out_size;
  assign out_rob_idx_o  = r_out_rob_idx;
  assign out_misalign_o = r_out_misalign;

endmodule

// File: tb/tb_lsu_agu_sched.sv
// Bench for lsu_agu_sched: directed vector table followed by randomized traffic against a reference model.
module tb_lsu_agu_sched;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic        ld_valid_i, st_valid_i, out_ready_i;
  logic        ld_ready_o, st_ready_o;
  logic [63:0] ld_base_i, ld_offset_i, st_base_i, st_offset_i;
  logic [1:0]  ld_size_i, st_size_i;
  logic [5:0]  ld_rob_idx_i, st_rob_idx_i;
  logic        out_valid_o, out_is_store_o, out_misalign_o;
  logic [38:0] out_addr_o;
  logic [1:0]  out_size_o;
  logic [5:0]  out_rob_idx_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lsu_agu_sched dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_base_i(ld_base_i),
    .ld_offset_i(ld_offset_i), .ld_size_i(ld_size_i), .ld_rob_idx_i(ld_rob_idx_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_base_i(st_base_i),
    .st_offset_i(st_offset_i), .st_size_i(st_size_i), .st_rob_idx_i(st_rob_idx_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_addr_o(out_addr_o),
    .out_is_store_o(out_is_store_o), .out_size_o(out_size_o),
    .out_rob_idx_o(out_rob_idx_o), .out_misalign_o(out_misalign_o)
  );

  typedef struct {
    logic        rst, flush, ldv, stv, ordy;
    logic [63:0] ld_base, ld_off;
    logic [1:0]  ld_size;
    logic [5:0]  ld_rob;
    logic        e_lr, e_sr, e_v;
    logic [38:0] e_addr;
    logic        e_st;
    logic [1:0]  e_size;
    logic [5:0]  e_rob;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic lv, logic sv, logic o,
                              logic [63:0] b, logic [63:0] off, logic [1:0] sz, logic [5:0] rb,
                              logic lr, logic sr, logic v, logic [38:0] a, logic st,
                              logic [1:0] esz, logic [5:0] erb, logic mis);
    vec_t t;
    t.rst = r; t.flush = f; t.ldv = lv; t.stv = sv; t.ordy = o;
    t.ld_base = b; t.ld_off = off; t.ld_size = sz; t.ld_rob = rb;
    t.e_lr = lr; t.e_sr = sr; t.e_v = v; t.e_addr = a; t.e_st = st;
    t.e_size = esz; t.e_rob = erb; t.e_mis = mis;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [38:0] a, input logic st,
                         input logic [1:0] sz, input logic [5:0] rb, input logic mis);
    chk({tag, ".valid"},    out_valid_o, v);
    chk({tag, ".addr"},     out_addr_o, a);
    chk({tag, ".is_store"}, out_is_store_o, st);
    chk({tag, ".size"},     out_size_o, sz);
    chk({tag, ".rob"},      out_rob_idx_o, rb);
    chk({tag, ".misalign"}, out_misalign_o, mis);
  endtask

  // Reference model state
  logic        m_valid, m_st, m_mis, m_last;
  logic [38:0] m_addr;
  logic [1:0]  m_size;
  logic [5:0]  m_rob;

  task automatic model_edge(input logic gl, input logic gs);
    logic [63:0] b, o, a;
    if (rst) begin
      m_valid = 0; m_addr = 0; m_st = 0; m_size = 0; m_rob = 0; m_mis = 0; m_last = 1;
    end else if (flush_i) begin
      m_valid = 0;
    end else if (gl || gs) begin
      b = gs ? st_base_i : ld_base_i;
      o = gs ? st_offset_i : ld_offset_i;
      a = (b + o) % (64'd1 << 39);
      m_valid = 1;
      m_addr  = a[38:0];
      m_st    = gs;
      m_size  = gs ? st_size_i : ld_size_i;
      m_rob   = gs ? st_rob_idx_i : ld_rob_idx_i;
      m_mis   = (a % (64'd1 << m_size)) != 0;
      m_last  = gs;
    end else if (out_ready_i) begin
      m_valid = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] L_B, L_O, W_B;
    logic p_ldv, p_stv, p_lg, p_sg, e_lg, e_sg, can;
    L_B = 64'h1000; L_O = 64'h8; W_B = 64'h7F_FFFF_FFFF;

    // Directed vectors; stores always use base 0x2000, offset 0x10, size 2, rob 9.
    tbl.push_back(mk(1,0,1,1,1, L_B,L_O,3,5, 0,0, 0,39'h0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1, L_B,L_O,3,5, 1,0, 1,39'h1008,0,3,5,0));
    tbl.push_back(mk(0,0,0,0,1, L_B,L_O,3,5, 0,0, 0,39'h1008,0,3,5,0));
    tbl.push_back(mk(1,0,0,0,1, L_B,L_O,3,5, 0,0, 0,39'h0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,1, L_B,L_O,3,5, 1,0, 1,39'h1008,0,3,5,0));
    tbl.push_back(mk(0,0,1,1,1, L_B,L_O,3,5, 0,1, 1,39'h2010,1,2,9,0));
    tbl.push_back(mk(0,0,1,1,1, L_B,L_O,3,5, 1,0, 1,39'h1008,0,3,5,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,1,1,0, L_B,L_O,3,5, 0,0, 1,39'h1008,0,3,5,0));
    tbl.push_back(mk(0,0,1,1,1, L_B,L_O,3,5, 0,1, 1,39'h2010,1,2,9,0));
    tbl.push_back(mk(0,0,1,0,1, W_B,64'h2,2,3, 1,0, 1,39'h1,0,2,3,1));
    tbl.push_back(mk(0,0,1,0,1, W_B,64'h2,0,3, 1,0, 1,39'h1,0,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, W_B,64'h2,0,3, 0,0, 0,39'h1,0,0,3,0));
    tbl.push_back(mk(0,0,1,1,1, L_B,L_O,3,5, 0,1, 1,39'h2010,1,2,9,0));
    tbl.push_back(mk(1,0,1,1,1, L_B,L_O,3,5, 0,0, 0,39'h0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,1, L_B,L_O,3,5, 1,0, 1,39'h1008,0,3,5,0));
    tbl.push_back(mk(0,0,1,0,1, 64'h1001,64'h0,1,7, 1,0, 1,39'h1001,0,1,7,1));
    tbl.push_back(mk(0,0,1,0,1, 64'h1004,64'h0,3,7, 1,0, 1,39'h1004,0,3,7,1));
    tbl.push_back(mk(0,0,1,0,1, 64'h1004,64'h0,2,7, 1,0, 1,39'h1004,0,2,7,0));

    rst = 1; flush_i = 0; ld_valid_i = 0; st_valid_i = 0; out_ready_i = 0;
    ld_base_i = 0; ld_offset_i = 0; ld_size_i = 0; ld_rob_idx_i = 0;
    st_base_i = 64'h2000; st_offset_i = 64'h10; st_size_i = 2; st_rob_idx_i = 9;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush_i = tbl[i].flush; ld_valid_i = tbl[i].ldv;
      st_valid_i = tbl[i].stv; out_ready_i = tbl[i].ordy;
      ld_base_i = tbl[i].ld_base; ld_offset_i = tbl[i].ld_off;
      ld_size_i = tbl[i].ld_size; ld_rob_idx_i = tbl[i].ld_rob;
      #3;
      chk($sformatf("v%0d.ld_ready", i), ld_ready_o, tbl[i].e_lr);
      chk($sformatf("v%0d.st_ready", i), st_ready_o, tbl[i].e_sr);
      @(posedge clk); #1;
      chk_out($sformatf("v%0d", i), tbl[i].e_v, tbl[i].e_addr, tbl[i].e_st,
              tbl[i].e_size, tbl[i].e_rob, tbl[i].e_mis);
    end

    // Randomized traffic; first cycle is a reset so the model starts in sync.
    m_valid = 0; m_addr = 0; m_st = 0; m_size = 0; m_rob = 0; m_mis = 0; m_last = 1;
    p_ldv = 0; p_stv = 0; p_lg = 0; p_sg = 0;
    for (int c = 0; c < 2000; c++) begin
      rst     = (c == 0) || ($urandom_range(0, 63) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      if (!(p_ldv && !p_lg)) begin
        ld_valid_i = $urandom_range(0, 1);
        ld_base_i = {$urandom, $urandom}; ld_offset_i = {$urandom, $urandom};
        ld_size_i = 2'($urandom_range(0, 3)); ld_rob_idx_i = 6'($urandom);
      end
      if (!(p_stv && !p_sg)) begin
        st_valid_i = $urandom_range(0, 1);
        st_base_i = {$urandom, $urandom}; st_offset_i = {$urandom, $urandom};
        st_size_i = 2'($urandom_range(0, 3)); st_rob_idx_i = 6'($urandom);
      end
      can  = !m_valid || out_ready_i;
      e_lg = can && !flush_i && !rst && ld_valid_i && (!st_valid_i || m_last);
      e_sg = can && !flush_i && !rst && st_valid_i && !e_lg;
      #3;
      chk("rnd.ld_ready", ld_ready_o, e_lg);
      chk("rnd.st_ready", st_ready_o, e_sg);
      model_edge(e_lg, e_sg);
      p_ldv = ld_valid_i && !rst && !flush_i; p_stv = st_valid_i && !rst && !flush_i;
      p_lg = e_lg; p_sg = e_sg;
      @(posedge clk); #1;
      chk_out("rnd", m_valid, m_addr, m_st, m_size, m_rob, m_mis);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
